// File: rtl/conv_scheduler_if.sv
// Handshake/bus bundle between the conv_scheduler and its environment:
// job control, upstream vector stream, datapath drive, result tags and credit return.
interface conv_scheduler_if #(
  parameter int IMG_WIDTH = 16,
  parameter int IMG_NB    = 3,
  parameter int LEN_WIDTH = 16
);
  logic [LEN_WIDTH-1:0]        cfg_len;
  logic                        start;
  logic                        busy;
  logic                        done;
  logic [IMG_WIDTH*IMG_NB-1:0] up_img;
  logic                        up_val;
  logic                        up_rdy;
  logic [IMG_WIDTH*IMG_NB-1:0] dp_img;
  logic                        dp_val;
  logic                        res_val;
  logic                        res_last;
  logic                        credit_ret;

  modport master (
    output cfg_len, start, up_img, up_val, credit_ret,
    input  busy, done, up_rdy, dp_img, dp_val, res_val, res_last
  );

  modport slave (
    input  cfg_len, start, up_img, up_val, credit_ret,
    output busy, done, up_rdy, dp_img, dp_val, res_val, res_last
  );
endinterface

// File: rtl/conv_scheduler.sv
// Credit-based job scheduler feeding the fixed-latency convolution MAC chain.
// Optional CONV_SCHED_STATS_EN adds stall/transfer statistics counters.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | admitting vectors while credits and remaining length allow
// DRAIN | all vectors issued, waiting for the last-of-job tag at the chain output
// DONE  | one-cycle completion pulse
module conv_scheduler #(
  parameter int IMG_WIDTH = 16,
  parameter int IMG_NB    = 3,
  parameter int LATENCY   = 19,
  parameter int CREDITS   = 32,
  parameter int LEN_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  conv_scheduler_if.slave  bus
`ifdef CONV_SCHED_STATS_EN
  ,
  output logic [31:0]      stat_stall,
  output logic [31:0]      stat_xfer
`endif
);
  localparam int DW = IMG_WIDTH * IMG_NB;
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CREDITS_MAX = CW'(CREDITS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [LEN_WIDTH-1:0] r_remaining;
  logic [CW-1:0]        r_credits;
  logic [DW-1:0]        r_dp_img;
  logic                 r_dp_val;
  logic                 r_dp_last;
  logic [LATENCY-1:0]   r_tag_val;
  logic [LATENCY-1:0]   r_tag_last;

  logic w_up_rdy;
  logic w_xfer;
  logic w_is_last;
  logic w_start_job;
  logic w_busy;
  logic w_done;

  assign w_is_last   = (r_remaining == LEN_WIDTH'(1));
  assign w_up_rdy    = (r_state == S_RUN) && (r_credits != '0) && (r_remaining != '0);
  assign w_xfer      = bus.up_val && w_up_rdy;
  assign w_start_job = (r_state == S_IDLE) && bus.start && (bus.cfg_len != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = (bus.cfg_len != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_xfer && w_is_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        // Only one job is ever in flight, so the last tag at the tail ends it.
        if (r_tag_val[LATENCY-1] && r_tag_last[LATENCY-1]) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_credits   <= CREDITS_MAX;
      r_dp_img    <= '0;
      r_dp_val    <= 1'b0;
      r_dp_last   <= 1'b0;
      r_tag_val   <= '0;
      r_tag_last  <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_start_job) begin
        r_remaining <= bus.cfg_len;
      end else if (w_xfer) begin
        r_remaining <= r_remaining - LEN_WIDTH'(1);
      end

      // Issue and return in the same cycle cancel; returns saturate at full depth.
      if (w_xfer && !bus.credit_ret) begin
        r_credits <= r_credits - CW'(1);
      end else if (!w_xfer && bus.credit_ret && (r_credits != CREDITS_MAX)) begin
        r_credits <= r_credits + CW'(1);
      end

      r_dp_val  <= w_xfer;
      r_dp_last <= w_xfer && w_is_last;
      if (w_xfer) r_dp_img <= bus.up_img;

      // Tags enter alongside dp_val so the tail lines up with the chain output.
      r_tag_val  <= {r_tag_val[LATENCY-2:0], r_dp_val};
      r_tag_last <= {r_tag_last[LATENCY-2:0], r_dp_last};
    end
  end

  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.up_rdy   = w_up_rdy;
  assign bus.dp_img   = r_dp_img;
  assign bus.dp_val   = r_dp_val;
  assign bus.res_val  = r_tag_val[LATENCY-1];
  assign bus.res_last = r_tag_val[LATENCY-1] && r_tag_last[LATENCY-1];

`ifdef CONV_SCHED_STATS_EN
  logic [31:0] r_stat_stall;
  logic [31:0] r_stat_xfer;
  logic        w_credit_stall;

  assign w_credit_stall = (r_state == S_RUN) && bus.up_val && !w_up_rdy &&
                          (r_credits == '0) && (r_remaining != '0);

  always_ff @(posedge clk) begin
    if (rst || w_start_job || ((r_state == S_IDLE) && bus.start)) begin
      r_stat_stall <= '0;
      r_stat_xfer  <= '0;
    end else begin
      if (w_credit_stall && (r_stat_stall != '1)) r_stat_stall <= r_stat_stall + 32'd1;
      if (w_xfer && (r_stat_xfer != '1))          r_stat_xfer  <= r_stat_xfer + 32'd1;
    end
  end

  assign stat_stall = r_stat_stall;
  assign stat_xfer  = r_stat_xfer;
`endif

endmodule
